// File: rtl/rstseq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default parameter values and the counter-width helper.
package rstseq_pkg;

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_GAP      = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4,
    S_ASSERT   = 3'd5
  } state_t;

  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam int DEF_SYNC_STAGES = 2;

  // One spare bit above the largest terminal count so no counter can wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rstseq_sync.sv
// Multi-flop synchronizer for asynchronous level inputs, cleared by reset_n.
module rstseq_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS reset domains one at a time with ack/timeout handshake.
// Optional macro RSTSEQ_REVERSE_ASSERT_EN: soft reset re-asserts domains highest-first.
//
// state    | meaning
// HOLD     | post-reset hold, counting HOLD_CYCLES before releasing domain 0
// WAIT_ACK | domain idx released, waiting for its ready (bounded by ACK_TIMEOUT)
// GAP      | ready seen, waiting STAGE_DELAY before the next release
// DONE     | every domain released and acknowledged
// ERROR    | domain idx failed to acknowledge in time
// ASSERT   | reverse-order re-assertion after soft reset (macro builds only)
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           soft_rst_req,
  input  logic [NUM_DOMAINS-1:0]         domain_ready,
  output logic [NUM_DOMAINS-1:0]         domain_rst_n,
  output logic                           seq_done,
  output logic                           seq_error,
  output logic [$clog2(NUM_DOMAINS)-1:0] err_domain
);

  localparam int IW = $clog2(NUM_DOMAINS);
  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);

  logic [NUM_DOMAINS-1:0] ready_s;
  logic                   soft_s, soft_q, soft_edge;
  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q;
  logic                   cnt_clr, cnt_run, step;
  logic [NUM_DOMAINS-1:0] rel_q, rel_d;

  rstseq_sync #(.STAGES(SYNC_STAGES), .WIDTH(NUM_DOMAINS)) u_sync_ready (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (domain_ready),
    .q       (ready_s)
  );

  rstseq_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_soft (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (soft_rst_req),
    .q       (soft_s)
  );

  assign soft_edge = soft_s & ~soft_q;
  assign cnt_run   = (state_q == S_HOLD) || (state_q == S_WAIT_ACK) ||
                     (state_q == S_GAP)  || (state_q == S_ASSERT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      soft_q  <= soft_s;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_run) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    step    = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          rel_d[0] = 1'b1;
          idx_d    = '0;
          state_d  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // ready is tested first so an ack on the expiry cycle still wins
        if (ready_s[idx_q])                     state_d = S_GAP;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1)) state_d = S_ERROR;
      end
      S_GAP: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          if (idx_q == IW'(NUM_DOMAINS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d                 = idx_q + 1'b1;
            rel_d[idx_q + 1'b1]   = 1'b1;
            state_d               = S_WAIT_ACK;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (soft_edge) begin
`ifdef RSTSEQ_REVERSE_ASSERT_EN
          idx_d                  = IW'(NUM_DOMAINS - 1);
          rel_d[NUM_DOMAINS - 1] = 1'b0;
          state_d                = S_ASSERT;
`else
          rel_d   = '0;
          state_d = S_HOLD;
`endif
        end
      end
      S_ASSERT: begin
`ifdef RSTSEQ_REVERSE_ASSERT_EN
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          if (idx_q == '0) begin
            state_d = S_HOLD;
          end else begin
            idx_d               = idx_q - 1'b1;
            rel_d[idx_q - 1'b1] = 1'b0;
            step                = 1'b1;
          end
        end
`else
        rel_d   = '0;
        state_d = S_HOLD;
`endif
      end
      default: begin
        rel_d   = '0;
        state_d = S_HOLD;
      end
    endcase
  end

  assign cnt_clr = (state_d != state_q) || step;

  always_comb begin
    seq_done   = (state_q == S_DONE);
    seq_error  = (state_q == S_ERROR);
    err_domain = (state_q == S_ERROR) ? idx_q : '0;
  end

  assign domain_rst_n = rel_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters: vector table for
// loopback and timeout timelines, hand sequences for soft reset and races.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] rdy_mask = 4'h0;
  logic [3:0] domain_ready;
  logic [3:0] domain_rst_n;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_domain;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  typedef struct {
    logic       restart;
    logic [3:0] mask;
    int         cyc;
    logic [3:0] rst;
    logic       done;
    logic       err;
    logic [1:0] edom;
  } vec_t;

  vec_t vecs[$];

  // Ready is looped back from each domain's own reset, gated per domain.
  assign domain_ready = domain_rst_n & rdy_mask;

  always #5 clock = ~clock;

  reset_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req),
    .domain_ready (domain_ready),
    .domain_rst_n (domain_rst_n),
    .seq_done     (seq_done),
    .seq_error    (seq_error),
    .err_domain   (err_domain)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
    cur += n;
  endtask

  task automatic chk(input string name, input logic [3:0] er, input logic ed,
                     input logic ee, input logic [1:0] edom);
    checks++;
    if (domain_rst_n !== er || seq_done !== ed || seq_error !== ee || err_domain !== edom) begin
      errors++;
      $display("FAIL %s cyc=%0d: got rst_n=%b done=%b err=%b dom=%0d, expected rst_n=%b done=%b err=%b dom=%0d",
               name, cur, domain_rst_n, seq_done, seq_error, err_domain, er, ed, ee, edom);
    end
  endtask

  task automatic do_reset(input logic [3:0] mask);
    reset_n      = 1'b0;
    soft_rst_req = 1'b0;
    rdy_mask     = mask;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cur     = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Loopback timeline: releases at 8, 27, 46, 65; done at 84.
    vecs.push_back('{1'b1, 4'hF,    0, 4'b0000, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,    7, 4'b0000, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,    8, 4'b0001, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   26, 4'b0001, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   27, 4'b0011, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   45, 4'b0011, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   46, 4'b0111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   64, 4'b0111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   65, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   83, 4'b1111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,   84, 4'b1111, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hF,  300, 4'b1111, 1'b1, 1'b0, 2'd0});
    // Domain 2 never acks: released at 46, error 1024 cycles later.
    vecs.push_back('{1'b1, 4'hB,   46, 4'b0111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hB, 1069, 4'b0111, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'hB, 1070, 4'b0111, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 4'hB, 1500, 4'b0111, 1'b0, 1'b1, 2'd2});

    #1;
    chk("reset_state", 4'b0000, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_held", 4'b0000, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].restart) do_reset(vecs[i].mask);
      step(vecs[i].cyc - cur);
      chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].done, vecs[i].err, vecs[i].edom);
    end

    // Soft reset out of ERROR (still domain 2 silent).
    soft_rst_req = 1'b1;
    step(2);
    chk("soft_err_pending", 4'b0111, 1'b0, 1'b1, 2'd2);
    step(1);
    chk("soft_err_taken", 4'b0000, 1'b0, 1'b0, 2'd0);
    soft_rst_req = 1'b0;
    cur = 0;
    step(8);
    chk("soft_err_rerun", 4'b0001, 1'b0, 1'b0, 2'd0);

    // Soft reset in DONE, then identical re-run timing.
    do_reset(4'hF);
    step(84);
    chk("done_before_soft", 4'b1111, 1'b1, 1'b0, 2'd0);
    soft_rst_req = 1'b1;
    step(2);
    chk("soft_done_pending", 4'b1111, 1'b1, 1'b0, 2'd0);
    step(1);
    chk("soft_done_taken", 4'b0000, 1'b0, 1'b0, 2'd0);
    soft_rst_req = 1'b0;
    cur = 0;
    step(7);
    chk("rerun_c7", 4'b0000, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("rerun_c8", 4'b0001, 1'b0, 1'b0, 2'd0);
    step(18);
    chk("rerun_c26", 4'b0001, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("rerun_c27", 4'b0011, 1'b0, 1'b0, 2'd0);
    step(56);
    chk("rerun_c83", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("rerun_c84", 4'b1111, 1'b1, 1'b0, 2'd0);

    // Soft reset while waiting on domain 1 is dropped.
    do_reset(4'b1101);
    step(100);
    chk("wait1_before_soft", 4'b0011, 1'b0, 1'b0, 2'd0);
    soft_rst_req = 1'b1;
    step(5);
    soft_rst_req = 1'b0;
    chk("wait1_soft_ignored", 4'b0011, 1'b0, 1'b0, 2'd0);
    step(95);
    rdy_mask = 4'hF;
    step(18);
    chk("wait1_c218", 4'b0011, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("wait1_c219", 4'b0111, 1'b0, 1'b0, 2'd0);
    step(37);
    chk("wait1_c256", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("wait1_c257", 4'b1111, 1'b1, 1'b0, 2'd0);
    step(143);
    chk("wait1_no_rerun", 4'b1111, 1'b1, 1'b0, 2'd0);

    // reset_n dropped in the GAP after domain 1 ack.
    do_reset(4'hF);
    step(35);
    chk("gap_before_rst", 4'b0011, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    #1;
    chk("gap_async_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cur = 0;
    step(8);
    chk("gap_restart_c8", 4'b0001, 1'b0, 1'b0, 2'd0);
    step(76);
    chk("gap_restart_done", 4'b1111, 1'b1, 1'b0, 2'd0);

    // Ready for domain 1 arrives on the very cycle its timeout expires.
    do_reset(4'b1101);
    step(1048);
    chk("race_c1048", 4'b0011, 1'b0, 1'b0, 2'd0);
    rdy_mask = 4'hF;
    step(18);
    chk("race_c1066", 4'b0011, 1'b0, 1'b0, 2'd0);
    step(1);
    chk("race_c1067", 4'b0111, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Orders release of NUM_DOMAINS downstream reset domains after the board-level power-on reset deasserts.
- Releases domains one at a time. Each domain must return a ready acknowledge before the next is released, with a per-domain timeout.
- Accepts a soft-reset request that re-asserts all domains and re-runs the sequence.
- Sits between the power-on reset generator and the functional blocks: display, audio, input.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset domains (2..8).
- HOLD_CYCLES, 8: cycles held in reset after reset_n deasserts, before domain 0 is released.
- STAGE_DELAY, 16: gap cycles between an accepted ack and the next domain release (>=1).
- ACK_TIMEOUT, 1024: cycles allowed for a domain's ready after its release (>=4).
- SYNC_STAGES, 2: synchronizer depth on domain_ready and soft_rst_req (>=2).

Ports:
- clock  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset, driven by the power-on reset generator.
- soft_rst_req  in  1  asynchronous level request; its synchronized rising edge triggers a soft reset.
- domain_ready  in  NUM_DOMAINS  per-domain asynchronous ready acknowledge.
- domain_rst_n  out  NUM_DOMAINS  per-domain active-low reset outputs, registered.
- seq_done  out  1  high when all domains are released and acknowledged.
- seq_error  out  1  high when a domain ack has timed out.
- err_domain  out  clog2(NUM_DOMAINS)  index of the domain that timed out.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: domain_rst_n=all 0, seq_done=0, seq_error=0, err_domain=0.
  - Internal: state=HOLD, counters=0, synchronizers cleared.
- Synchronizers: ready(i) is domain_ready[i] after SYNC_STAGES flops; soft_rst_req is synchronized the same way, then rising-edge detected.
- FSM states: HOLD, WAIT_ACK, GAP, DONE, ERROR, plus ASSERT (used only with the optional feature).
- HOLD: counts HOLD_CYCLES clocks. On the final count: domain_rst_n[0] goes to 1, idx=0, move to WAIT_ACK.
- WAIT_ACK(idx): timeout counter increments every cycle.
  - ready(idx)=1: go to GAP, clear counter.
  - Counter reaches ACK_TIMEOUT-1 with ready(idx)=0: go to ERROR.
  - If ready and timeout occur in the same cycle, ready wins.
- GAP: counts STAGE_DELAY cycles.
  - If idx<NUM_DOMAINS-1: idx increments, domain_rst_n[idx] goes to 1, move to WAIT_ACK.
  - If idx is the last domain: move to DONE.
- DONE: seq_done=1. Later drops of ready on any domain are ignored.
- ERROR:
  - seq_error=1 and err_domain=idx.
  - Domains already released stay released; remaining domains stay in reset.
  - Stays in ERROR until a soft reset or reset_n.
- Soft reset:
  - Accepted only in DONE or ERROR; an edge arriving in any other state is dropped, with no queuing.
  - On acceptance: domain_rst_n=all 0, and seq_done and seq_error clear, all on the next cycle.
  - Then enter HOLD; the sequence re-runs from domain 0.
- Latency: ack-to-next-release is exactly STAGE_DELAY+1 cycles after the synchronized ready is first high.
- Counters: width clog2 of the largest of HOLD_CYCLES, STAGE_DELAY and ACK_TIMEOUT, plus 1. Counters never wrap; each clears on every state entry.
- Reset mid-sequence: all outputs return to reset values immediately and asynchronously.
- domain_rst_n bits only rise in index order. No bit falls except on soft reset or reset_n.

Optional Feature:
- Macro: RSTSEQ_REVERSE_ASSERT_EN.
- Defined: an accepted soft reset enters ASSERT. Domains are re-asserted in reverse index order, highest first, one every STAGE_DELAY cycles. seq_done and seq_error clear on entry to ASSERT. Domain 0 is asserted last; the FSM then enters HOLD.
- Undefined: all domains are asserted together on the cycle after acceptance; the ASSERT state is absent.

Decomposition:
- Package rstseq_pkg holds:
  - state enum (HOLD, WAIT_ACK, GAP, DONE, ERROR, ASSERT);
  - counter-width function;
  - default parameter constants.
- One sub-module, rstseq_sync: parameterized SYNC_STAGES flop chain with async active-low clear. It is instantiated for the domain_ready vector and for soft_rst_req.

Test Plan (default parameters unless stated):
- Loopback, domain_ready=domain_rst_n: domain_rst_n[0] rises 8 cycles after reset_n release. Each later bit rises 16+1 cycles after the previous synchronized ack (SYNC_STAGES=2). seq_done=1 after domain 3 ack plus 17 cycles. seq_error stays 0.
- domain_ready[2] tied 0, others loopback: domains 0-1 released, domain 2 released, then seq_error=1 and err_domain=2 exactly 1024 cycles after domain_rst_n[2] rises. domain_rst_n[3]=0 throughout.
- Pulse soft_rst_req in DONE: all domain_rst_n go low within SYNC_STAGES+2 cycles, seq_done clears, full sequence repeats with identical timing. With RSTSEQ_REVERSE_ASSERT_EN, bits fall 3,2,1,0 at 16-cycle spacing.
- Pulse soft_rst_req during WAIT_ACK(1): ignored, sequence completes normally, no re-run.
- Drop reset_n during GAP after domain 1: domain_rst_n=0 asynchronously, seq_done=0. After release, the sequence restarts from HOLD.
- ready(1) asserted on the exact cycle its timeout expires: GAP is taken, no error flagged.
